// File: rtl/matmul_sp_sequencer_if.sv
// Handshake and datapath bundle between a 4x4 matmul requester, the sequencer and the
// pipelined scalar-product unit.
interface matmul_sp_sequencer_if #(
    parameter int Nbits = 8
);
    logic                  start;
    logic [16*Nbits-1:0]   mat_a;
    logic [16*Nbits-1:0]   mat_b;
    logic                  busy;
    logic                  done;
    logic [32*Nbits-1:0]   mat_c;
    logic [4*Nbits-1:0]    sp_a;
    logic [4*Nbits-1:0]    sp_b;
    logic [2*Nbits-1:0]    sp_out;

    // master: requester plus the scalar-product pipe; slave: the sequencer
    modport master (
        output start, mat_a, mat_b, sp_out,
        input  busy, done, mat_c, sp_a, sp_b
    );

    modport slave (
        input  start, mat_a, mat_b, sp_out,
        output busy, done, mat_c, sp_a, sp_b
    );
endinterface

// File: rtl/matmul_sp_sequencer.sv
// Issues the 16 row/column operand pairs of a 4x4 product to a pipelined scalar-product
// unit and collects the tagged results into C.
module matmul_sp_sequencer #(
    parameter int Nbits = 8,
    parameter int LAT   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    matmul_sp_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         k_reg, k_next;
    logic [Nbits-1:0]   a_reg [16];
    logic [Nbits-1:0]   b_reg [16];
    logic [2*Nbits-1:0] c_reg [16];
    logic [LAT-1:0]     vld_reg;
    logic [3:0]         tag_reg [LAT];
    logic               issue;
    logic               accept;

    assign issue  = (state_reg == ISSUE);
    assign accept = (state_reg == IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = ISSUE;
                    k_next     = 4'd0;
                end
            end
            ISSUE: begin
                k_next = k_reg + 4'd1;
                if (k_reg == 4'd15) state_next = DRAIN;
            end
            DRAIN: begin
                // the final issue carries tag 15; once it reaches the capture stage we are done
                if (vld_reg[LAT-1] && tag_reg[LAT-1] == 4'd15) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);

    // Operand copies are only loaded on acceptance, so they need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int n = 0; n < 16; n++) begin
                a_reg[n] <= bus.mat_a[n*Nbits +: Nbits];
                b_reg[n] <= bus.mat_b[n*Nbits +: Nbits];
            end
        end
    end

    // Tag/valid pipeline mirrors the scalar-product pipe latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_reg <= '0;
            for (int s = 0; s < LAT; s++) tag_reg[s] <= '0;
        end else begin
            vld_reg[0] <= issue;
            tag_reg[0] <= k_reg;
            for (int s = 1; s < LAT; s++) begin
                vld_reg[s] <= vld_reg[s-1];
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 16; n++) c_reg[n] <= '0;
        end else if (vld_reg[LAT-1]) begin
            c_reg[tag_reg[LAT-1]] <= bus.sp_out;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            // lane l carries A[i][l] and B[l][j] with i = k[3:2], j = k[1:0]
            assign bus.sp_a[gi*Nbits +: Nbits] = issue ? a_reg[{k_reg[3:2], LANE}] : '0;
            assign bus.sp_b[gi*Nbits +: Nbits] = issue ? b_reg[{LANE, k_reg[1:0]}] : '0;
        end
        for (gi = 0; gi < 16; gi++) begin : g_c
            assign bus.mat_c[gi*2*Nbits +: 2*Nbits] = c_reg[gi];
        end
    endgenerate
endmodule
